hilo_mul_ctrl: RTL and testbench

- Sequential control and result stage for the combinational 32x32 unsigned array multiplier (MULTU).
- Accepts MULT/MULTU/MTHI/MTLO from the CPU execute stage and latches operands.
- For signed MULT, feeds operand magnitudes to the multiplier and restores the product sign.
- Holds the multiplier inputs stable for a configurable multicycle window, then writes the architectural HI/LO registers. Raises busy so the pipeline stalls.

---
 rtl/hilo_mul_ctrl.sv | 129 ++++++++++++
 tb/tb_hilo_mul_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_ctrl.sv
// HI/LO multicycle multiply controller around an external 32x32 MULTU array.
// Optional accumulate ops (MADDU/MADD) enabled by defining HILO_MADD_EN.
module hilo_mul_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef HILO_MADD_EN
  input  logic [2:0]  op,
`else
  input  logic [1:0]  op,
`endif
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic        neg_q;
  logic        acc_q;
  logic        done_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] mul_a_q, mul_b_q;

  logic        is_mul, is_sgn, is_acc;
  logic        is_mthi, is_mtlo;
  logic [31:0] abs_rs, abs_rt;
  logic [63:0] prod, wr_d;

  always_comb begin
    is_mul  = 1'b0;
    is_sgn  = 1'b0;
    is_acc  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (op)
`ifdef HILO_MADD_EN
      3'b000: is_mul = 1'b1;
      3'b001: begin is_mul = 1'b1; is_sgn = 1'b1; end
      3'b010: is_mthi = 1'b1;
      3'b011: is_mtlo = 1'b1;
      3'b100: begin is_mul = 1'b1; is_acc = 1'b1; end
      3'b101: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
        is_acc = 1'b1;
      end
`else
      2'b00: is_mul = 1'b1;
      2'b01: begin is_mul = 1'b1; is_sgn = 1'b1; end
      2'b10: is_mthi = 1'b1;
      2'b11: is_mtlo = 1'b1;
`endif
      default: ;
    endcase
  end

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign abs_rs = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign abs_rt = rt_val[31] ? (~rt_val + 32'd1) : rt_val;

  assign prod = neg_q ? (~mul_z + 64'd1) : mul_z;

`ifdef HILO_MADD_EN
  assign wr_d = acc_q ? ({hi_q, lo_q} + prod) : prod;
`else
  assign wr_d = prod;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      neg_q   <= 1'b0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && is_mul) begin
            mul_a_q <= is_sgn ? abs_rs : rs_val;
            mul_b_q <= is_sgn ? abs_rt : rt_val;
            neg_q   <= is_sgn & (rs_val[31] ^ rt_val[31]);
            acc_q   <= is_acc;
            count_q <= 4'(MUL_CYCLES - 1);
            state_q <= CALC;
          end else if (start && is_mthi) begin
            hi_q <= rs_val;
          end else if (start && is_mtlo) begin
            lo_q <= rs_val;
          end
        end
        CALC: begin
          if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
          end else begin
            {hi_q, lo_q} <= wr_d;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == CALC);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural MULTU array.
// Covers MADD ops too when HILO_MADD_EN is defined.
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
`ifdef HILO_MADD_EN
  logic [2:0]  op;
  localparam logic [2:0] MULTU = 3'b000, MULT = 3'b001;
  localparam logic [2:0] MTHI = 3'b010, MTLO = 3'b011;
  localparam logic [2:0] MADDU = 3'b100, MADD = 3'b101;
`else
  logic [1:0]  op;
  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01;
  localparam logic [1:0] MTHI = 2'b10, MTLO = 2'b11;
`endif
  logic [31:0] rs_val, rt_val;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int nb;

  always #5 clk = ~clk;

  assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

  hilo_mul_ctrl #(.MUL_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // launch a multiply and count the busy cycles until it retires
  task automatic run_mul(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
    start  = 1'b1;
    op     = o[$bits(op)-1:0];
    rs_val = a;
    rt_val = b;
    step();
    start = 1'b0;
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      step();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0;
    rs_val = '0; rt_val = '0;
    step(); step();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mula", mul_a, 0);
    reset = 1'b1;
    step();

    // abandon an in-flight multiply
    start = 1'b1; op = MULTU; rs_val = 32'd7; rt_val = 32'd9;
    step();
    start = 1'b0;
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    reset = 1'b1;
    step();
    chk("mid_no_done1", done, 0);
    step();
    chk("mid_no_done2", done, 0);
    chk("mid_lo_still0", lo, 0);

    run_mul(3'(MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("ff_busy_cycles", nb, 2);
    chk("ff_hi", hi, 64'hFFFFFFFE);
    chk("ff_lo", lo, 64'h00000001);
    chk("ff_done", done, 1);
    step();
    chk("ff_done_once", done, 0);

    start = 1'b1; op = MULT; rs_val = 32'hFFFFFFFD; rt_val = 32'd5;
    step();
    start = 1'b0;
    chk("m35_mula", mul_a, 3);
    chk("m35_mulb", mul_b, 5);
    step(); step();
    chk("m35_hi", hi, 64'hFFFFFFFF);
    chk("m35_lo", lo, 64'hFFFFFFF1);
    chk("m35_done", done, 1);

    run_mul(3'(MULT), 32'h80000000, 32'h80000000);
    chk("m8_hi", hi, 64'h40000000);
    chk("m8_lo", lo, 0);
    run_mul(3'(MULT), 32'h0, 32'hFFFFFFFF);
    chk("m0_hi", hi, 0);
    chk("m0_lo", lo, 0);

    start = 1'b1; op = MTHI; rs_val = 32'h12345678;
    step();
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 64'h12345678);
    op = MTLO; rs_val = 32'h9ABCDEF0;
    step();
    start = 1'b0;
    chk("mtlo_busy", busy, 0);
    chk("mtlo_lo", lo, 64'h9ABCDEF0);
    chk("mtlo_hi", hi, 64'h12345678);
    chk("mtlo_done", done, 0);

    // second request held through busy and the retire edge
    start = 1'b1; op = MULTU; rs_val = 32'd2; rt_val = 32'd3;
    step();
    rs_val = 32'd100; rt_val = 32'd100;
    chk("b2b_busy", busy, 1);
    step();
    step();
    start = 1'b0;
    chk("b2b_lo", lo, 6);
    chk("b2b_hi", hi, 0);
    chk("b2b_idle", busy, 0);
    step();
    chk("b2b_still_idle", busy, 0);
    chk("b2b_lo_kept", lo, 6);

`ifdef HILO_MADD_EN
    start = 1'b1; op = MTHI; rs_val = 32'h0;
    step();
    op = MTLO; rs_val = 32'hFFFFFFFF;
    step();
    start = 1'b0;
    run_mul(MADDU, 32'd1, 32'd1);
    chk("maddu_hi", hi, 1);
    chk("maddu_lo", lo, 0);
    run_mul(MADD, 32'hFFFFFFFF, 32'd1);
    chk("madd_hi", hi, 0);
    chk("madd_lo", lo, 64'hFFFFFFFF);
    start = 1'b1; op = 3'b110; rs_val = 32'h55;
    step();
    start = 1'b0;
    chk("op110_busy", busy, 0);
    chk("op110_lo", lo, 64'hFFFFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
